// File: rtl/segment7_decoder.sv
// Recovers hex digits from sampled 7-segment display lines: debounces the sampled
// pattern, decodes it once it has been stable, and hands it off with a ready/valid flag.
module segment7_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] segment_led,
    input  logic       out_ready,
    output logic [3:0] seg_data,
    output logic       dp,
    output logic       data_valid,
    output logic       blank,
    output logic       seg_error,
    output logic [7:0] error_count,
    output logic       overrun
);

    typedef enum logic [1:0] {
        UNSTABLE = 2'd0,
        SETTLING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CYCLES);

    localparam logic [6:0] FONT [16] = '{
        7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71
    };

    state_t     state_reg, state_next;
    logic [7:0] count_reg, count_next;
    logic [8:0] sample_reg;
    logic [8:0] prev_reg;

    logic       same_sample;
    logic       digit_enabled;
    logic       accept;

    logic [15:0] match;
    logic        hit;
    logic [3:0]  digit;
    logic        blank_pattern;

    logic [3:0] seg_data_reg, seg_data_next;
    logic       dp_reg, dp_next;
    logic       data_valid_reg, data_valid_next;
    logic       blank_reg, blank_next;
    logic       seg_error_reg, seg_error_next;
    logic [7:0] error_count_reg, error_count_next;
    logic       overrun_reg, overrun_next;

    // Input capture plus one stage of history so stability is judged on registered data only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_reg <= 9'h1FF;
            prev_reg   <= 9'h1FF;
        end else begin
            sample_reg <= segment_led;
            prev_reg   <= sample_reg;
        end
    end

    assign same_sample   = (sample_reg == prev_reg);
    assign digit_enabled = ~sample_reg[8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= UNSTABLE;
            count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // The counter starts at 2 because two matching samples already exist on entry.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        accept     = 1'b0;
        case (state_reg)
            UNSTABLE: begin
                if (digit_enabled && same_sample) begin
                    state_next = SETTLING;
                    count_next = 8'd2;
                end else begin
                    count_next = 8'd0;
                end
            end
            SETTLING: begin
                if (!digit_enabled || !same_sample) begin
                    state_next = UNSTABLE;
                    count_next = 8'd0;
                end else if (count_reg >= STABLE_LIMIT) begin
                    state_next = LOCKED;
                    accept     = 1'b1;
                end else begin
                    count_next = count_reg + 8'd1;
                end
            end
            LOCKED: begin
                if (!digit_enabled || !same_sample) begin
                    state_next = UNSTABLE;
                    count_next = 8'd0;
                end
            end
            default: begin
                state_next = UNSTABLE;
                count_next = 8'd0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_font_match
            assign match[gi] = (sample_reg[6:0] == FONT[gi]);
        end
    endgenerate

    assign hit           = |match;
    assign blank_pattern = (sample_reg[6:0] == 7'h00);

    always_comb begin
        digit = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (match[i]) begin
                digit = 4'(i);
            end
        end
    end

    // A fresh digit on the consume edge keeps data_valid high and is not an overrun.
    always_comb begin
        seg_data_next    = seg_data_reg;
        dp_next          = dp_reg;
        data_valid_next  = data_valid_reg;
        blank_next       = blank_reg;
        seg_error_next   = 1'b0;
        error_count_next = error_count_reg;
        overrun_next     = overrun_reg;

        if (data_valid_reg && out_ready) begin
            data_valid_next = 1'b0;
        end

        if (accept) begin
            if (hit) begin
                seg_data_next   = digit;
                dp_next         = sample_reg[7];
                blank_next      = 1'b0;
                data_valid_next = 1'b1;
                if (data_valid_reg && !out_ready) begin
                    overrun_next = 1'b1;
                end
            end else if (blank_pattern) begin
                blank_next = 1'b1;
                dp_next    = sample_reg[7];
            end else begin
                seg_error_next = 1'b1;
                blank_next     = 1'b0;
                if (error_count_reg != 8'hFF) begin
                    error_count_next = error_count_reg + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_data_reg    <= 4'd0;
            dp_reg          <= 1'b0;
            data_valid_reg  <= 1'b0;
            blank_reg       <= 1'b1;
            seg_error_reg   <= 1'b0;
            error_count_reg <= 8'd0;
            overrun_reg     <= 1'b0;
        end else begin
            seg_data_reg    <= seg_data_next;
            dp_reg          <= dp_next;
            data_valid_reg  <= data_valid_next;
            blank_reg       <= blank_next;
            seg_error_reg   <= seg_error_next;
            error_count_reg <= error_count_next;
            overrun_reg     <= overrun_next;
        end
    end

    assign seg_data    = seg_data_reg;
    assign dp          = dp_reg;
    assign data_valid  = data_valid_reg;
    assign blank       = blank_reg;
    assign seg_error   = seg_error_reg;
    assign error_count = error_count_reg;
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_segment7_decoder.sv
// Self-checking bench for segment7_decoder: directed scenarios plus randomized
// display traffic compared against a run-length based behavioural model.
module tb_segment7_decoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] segment_led;
    logic       out_ready;
    logic [3:0] seg_data;
    logic       dp;
    logic       data_valid;
    logic       blank;
    logic       seg_error;
    logic [7:0] error_count;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    // Model state: outputs plus the current run of identical raw samples.
    logic [3:0] m_data;
    logic       m_dp, m_valid, m_blank, m_err, m_ovr;
    logic [7:0] m_cnt;
    logic [8:0] m_last;
    int         m_run;

    localparam logic [16:0] RESET_VEC = {4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1'b0};

    always #5 clk = ~clk;

    segment7_decoder #(.STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .segment_led(segment_led),
        .out_ready  (out_ready),
        .seg_data   (seg_data),
        .dp         (dp),
        .data_valid (data_valid),
        .blank      (blank),
        .seg_error  (seg_error),
        .error_count(error_count),
        .overrun    (overrun)
    );

    function automatic logic [6:0] font(input int d);
        case (d)
            0: return 7'h3f;  1: return 7'h06;  2: return 7'h5b;  3: return 7'h4f;
            4: return 7'h66;  5: return 7'h6d;  6: return 7'h7d;  7: return 7'h07;
            8: return 7'h7f;  9: return 7'h6f;  10: return 7'h77; 11: return 7'h7c;
            12: return 7'h39; 13: return 7'h5e; 14: return 7'h79; default: return 7'h71;
        endcase
    endfunction

    function automatic int lookup(input logic [6:0] p);
        for (int d = 0; d < 16; d++) begin
            if (font(d) == p) return d;
        end
        return -1;
    endfunction

    function automatic logic [16:0] got_vec();
        return {seg_data, dp, data_valid, blank, seg_error, error_count, overrun};
    endfunction

    function automatic logic [16:0] exp_vec();
        return {m_data, m_dp, m_valid, m_blank, m_err, m_cnt, m_ovr};
    endfunction

    // Drive one clock of inputs, advance the model on the edge, settle 1ns after it.
    task automatic tick(input logic [8:0] led, input logic rdy, input logic r);
        int d;
        rst         = r;
        segment_led = led;
        out_ready   = rdy;
        @(posedge clk);
        if (r) begin
            m_data = 4'd0; m_dp = 1'b0; m_valid = 1'b0; m_blank = 1'b1;
            m_err = 1'b0; m_cnt = 8'd0; m_ovr = 1'b0;
            m_last = 9'h1FF; m_run = 1;
        end else begin
            m_err = 1'b0;
            // A pattern is taken once it has been seen on S+1 consecutive edges.
            if (m_run == S + 1 && !m_last[8]) begin
                d = lookup(m_last[6:0]);
                if (d >= 0) begin
                    if (m_valid && !rdy) m_ovr = 1'b1;
                    m_data = 4'(d); m_dp = m_last[7]; m_blank = 1'b0; m_valid = 1'b1;
                end else if (m_last[6:0] == 7'h00) begin
                    m_blank = 1'b1; m_dp = m_last[7];
                    if (m_valid && rdy) m_valid = 1'b0;
                end else begin
                    m_err = 1'b1; m_blank = 1'b0;
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                    if (m_valid && rdy) m_valid = 1'b0;
                end
            end else if (m_valid && rdy) begin
                m_valid = 1'b0;
            end
            if (led == m_last) begin
                if (m_run < 1000) m_run++;
            end else begin
                m_last = led;
                m_run  = 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(9'h05B, 1'b0, 1'b1);
        tick(9'h05B, 1'b1, 1'b1);
        checks++;
        if (got_vec() !== RESET_VEC) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", got_vec(), RESET_VEC);
        end
    endtask

    task automatic test_hold();
        tick(9'h1FF, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick(9'h05B, 1'b0, 1'b0);
            checks++;
            if (data_valid !== (i >= 6)) begin
                failures++;
                $display("FAIL hold_latency edge=%0d got=%b exp=%b", i, data_valid, (i >= 6));
            end
            checks++;
            if (got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL hold_model edge=%0d got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if ({seg_data, dp} !== {4'd2, 1'b0}) begin
            failures++;
            $display("FAIL hold_data got=%h/%b exp=2/0", seg_data, dp);
        end
    endtask

    task automatic test_ready_sequence();
        logic [8:0] pat [2];
        logic [4:0] want [2];
        int         vcount;
        logic [4:0] seen;
        pat[0] = 9'h0FF; pat[1] = 9'h039;
        want[0] = {4'h8, 1'b1}; want[1] = {4'hC, 1'b0};
        tick(9'h1FF, 1'b0, 1'b1);
        for (int p = 0; p < 2; p++) begin
            vcount = 0;
            seen   = 5'h1F;
            for (int i = 0; i < 8; i++) begin
                tick(pat[p], 1'b1, 1'b0);
                if (data_valid === 1'b1) begin
                    vcount++;
                    seen = {seg_data, dp};
                end
                checks++;
                if (got_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL ready_model phase=%0d cycle=%0d got=%h exp=%h", p, i, got_vec(), exp_vec());
                end
            end
            checks++;
            if (vcount !== 1 || seen !== want[p]) begin
                failures++;
                $display("FAIL ready_result phase=%0d valid_cycles=%0d data=%h exp 1 cycle data=%h", p, vcount, seen, want[p]);
            end
        end
    endtask

    task automatic test_alternate();
        int vcount = 0;
        tick(9'h1FF, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 3; i++) begin
                tick((k % 2 == 0) ? 9'h006 : 9'h05B, 1'b0, 1'b0);
                if (data_valid !== 1'b0) vcount++;
                checks++;
                if (got_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL alternate_model k=%0d got=%h exp=%h", k, got_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (vcount !== 0) begin
            failures++;
            $display("FAIL alternate_no_valid got=%0d valid cycles exp=0", vcount);
        end
    endtask

    task automatic test_error();
        int pulses = 0;
        tick(9'h1FF, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) tick(9'h006, 1'b0, 1'b0);
        for (int n = 0; n < 260; n++) begin
            for (int i = 0; i < 7; i++) begin
                tick((i == 6) ? 9'h1FF : 9'h049, 1'b0, 1'b0);
                if (seg_error === 1'b1) pulses++;
                if (n < 3) begin
                    checks++;
                    if (got_vec() !== exp_vec()) begin
                        failures++;
                        $display("FAIL error_model n=%0d cycle=%0d got=%h exp=%h", n, i, got_vec(), exp_vec());
                    end
                end
            end
            if (n == 2) begin
                checks++;
                if (pulses !== 3 || error_count !== 8'd3 || data_valid !== 1'b1 || seg_data !== 4'd1) begin
                    failures++;
                    $display("FAIL error_three pulses=%0d count=%0d valid=%b data=%h exp 3/3/1/1",
                             pulses, error_count, data_valid, seg_data);
                end
            end
        end
        checks++;
        if (pulses !== 260 || error_count !== 8'd255) begin
            failures++;
            $display("FAIL error_saturate pulses=%0d count=%0d exp 260/255", pulses, error_count);
        end
    endtask

    task automatic test_overrun();
        tick(9'h1FF, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) tick(9'h006, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) tick(9'h07F, 1'b0, 1'b0);
        checks++;
        if ({seg_data, data_valid, overrun} !== {4'd8, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL overrun_set got data=%h valid=%b ovr=%b exp 8/1/1", seg_data, data_valid, overrun);
        end
        tick(9'h07F, 1'b1, 1'b0);
        checks++;
        if ({data_valid, overrun} !== 2'b01) begin
            failures++;
            $display("FAIL overrun_sticky got valid=%b ovr=%b exp 0/1", data_valid, overrun);
        end
        checks++;
        if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL overrun_model got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_settle();
        tick(9'h1FF, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick(9'h06D, 1'b0, 1'b0);
        tick(9'h06D, 1'b0, 1'b1);
        checks++;
        if (got_vec() !== RESET_VEC) begin
            failures++;
            $display("FAIL settle_reset got=%h exp=%h", got_vec(), RESET_VEC);
        end
        for (int i = 1; i <= 8; i++) begin
            tick(9'h06D, 1'b0, 1'b0);
            checks++;
            if (data_valid !== (i >= 6) || (i >= 6 && seg_data !== 4'd5)) begin
                failures++;
                $display("FAIL settle_accept edge=%0d got valid=%b data=%h exp valid=%b data=5",
                         i, data_valid, seg_data, (i >= 6));
            end
        end
    endtask

    function automatic logic [8:0] random_pattern();
        int sel = $urandom_range(0, 9);
        logic dpb = 1'($urandom_range(0, 1));
        if (sel <= 5) return {1'b0, dpb, font($urandom_range(0, 15))};
        if (sel == 6) return {1'b0, dpb, 7'h00};
        if (sel == 7) return {1'b0, dpb, 7'h49};
        if (sel == 8) return {1'b1, 8'($urandom)};
        return 9'($urandom);
    endfunction

    task automatic test_random();
        logic [8:0] pat;
        int         hold;
        tick(9'h1FF, 1'b0, 1'b1);
        for (int n = 0; n < 350; n++) begin
            pat  = random_pattern();
            hold = $urandom_range(1, 9);
            for (int i = 0; i < hold; i++) begin
                tick(pat, 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
                checks++;
                if (got_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL random_model seg=%0d pat=%h got=%h exp=%h", n, pat, got_vec(), exp_vec());
                end
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        segment_led = 9'h1FF;
        out_ready   = 1'b0;
        test_reset();
        test_hold();
        test_ready_sequence();
        test_alternate();
        test_error();
        test_overrun();
        test_reset_mid_settle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
